// File: rtl/shift_pkg.sv
// Shared types for the shift result stage: shift opcodes and the N/Z/C/V flag bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_pkg;

    typedef enum logic [1:0] {
        SRL = 2'b00,
        SRA = 2'b01,
        SLL = 2'b10,
        SLA = 2'b11
    } shift_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } shift_flags_t;

    localparam int SKID_DEPTH = 2;

    function automatic logic is_right_shift(shift_op_e op);
        return (op == SRL) || (op == SRA);
    endfunction

endpackage

// File: rtl/shift_flag_calc.sv
// Derives N/Z/C/V for one shift operation from its operands and the shifter's result.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the flags are captured.
import shift_pkg::*;

module shift_flag_calc #(
    parameter int WIDTH = 8
) (
    input  shift_op_e          sel,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   shamt,
    input  logic [WIDTH-1:0]   data,
    output shift_flags_t       flags
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] W_VEC    = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] MAX_SPAN = WIDTH'(WIDTH - 1);

    logic [WIDTH-1:0] shamt_m1;
    logic [WIDTH-1:0] right_view;
    logic [WIDTH-1:0] left_view;
    logic [WIDTH-1:0] span;
    logic [WIDTH-1:0] sign_mask;
    logic [WIDTH-1:0] sign_diff;

    // The last bit shifted out sits at bit 0 (right) or the MSB (left) after s-1 steps.
    assign shamt_m1   = shamt - ONE;
    assign right_view = a >> shamt_m1;
    assign left_view  = a << shamt_m1;

    // Overflow looks at the sign bit plus the next min(s, WIDTH-1) bits below it.
    assign span      = (shamt > MAX_SPAN) ? MAX_SPAN : shamt;
    assign sign_mask = ~({WIDTH{1'b1}} >> (span + ONE));
    assign sign_diff = a ^ {WIDTH{a[WIDTH-1]}};

    always_comb begin
        flags   = '0;
        flags.n = data[WIDTH-1];
        flags.z = (data == '0);

        if (shamt == '0) begin
            flags.c = 1'b0;
        end else if (shamt <= W_VEC) begin
            flags.c = is_right_shift(sel) ? right_view[0] : left_view[WIDTH-1];
        end else begin
            flags.c = (sel == SRA) ? a[WIDTH-1] : 1'b0;
        end

        flags.v = (sel == SLA) && (|(sign_diff & sign_mask));
    end

endmodule

// File: rtl/shift_flag_stage.sv
// Registers shift results with their flags into a 2-entry skid buffer for the next consumer.
// Latency: accepted at edge k, presented on result_o/flags_o after edge k; 1 transfer/cycle.
// Backpressure: ready_o drops only when both entries are held; head output holds while stalled.
import shift_pkg::*;

module shift_flag_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [1:0]         sel_i,
    input  logic [WIDTH-1:0]   A_i,
    input  logic [WIDTH-1:0]   shamt_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [WIDTH-1:0]   result_o,
    output logic [3:0]         flags_o,
    output logic [CNT_W-1:0]   op_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]        occ;
    logic              head;
    logic              tail;
    logic              push;
    logic              pop;
    shift_flags_t      cap_flags;
    logic [WIDTH-1:0]  res_mem [SKID_DEPTH];
    shift_flags_t      flg_mem [SKID_DEPTH];

    shift_flag_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .sel   (shift_op_e'(sel_i)),
        .a     (A_i),
        .shamt (shamt_i),
        .data  (data_i),
        .flags (cap_flags)
    );

    assign ready_o  = (occ < 2'(SKID_DEPTH));
    assign valid_o  = (occ != 2'd0);
    assign push     = valid_i & ready_o;
    assign pop      = valid_o & ready_i;
    assign result_o = res_mem[head];
    assign flags_o  = flg_mem[head];

    // Entries are cleared on reset so the idle outputs read as zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ  <= 2'd0;
            head <= 1'b0;
            tail <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                res_mem[i] <= '0;
                flg_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                res_mem[tail] <= data_i;
                flg_mem[tail] <= cap_flags;
                tail          <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_cnt_o <= '0;
        end else if (push && (op_cnt_o != CNT_MAX)) begin
            op_cnt_o <= op_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_shift_flag_stage.sv
// Bench for shift_flag_stage: directed flag cases, stall/skid ordering, random traffic, reset flush.
// Latency: n/a.
// Backpressure: ready_i is driven both held low and randomly.
module tb_shift_flag_stage;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [1:0]    sel_i;
    logic [W-1:0]  A_i;
    logic [W-1:0]  shamt_i;
    logic [W-1:0]  data_i;
    logic          valid_o;
    logic          ready_i;
    logic [W-1:0]  result_o;
    logic [3:0]    flags_o;
    logic [CW-1:0] op_cnt_o;

    int checks = 0;
    int errors = 0;
    int cnt_model = 0;

    logic [11:0]   sb [$];
    logic [11:0]   exp_e;
    logic          fi;
    logic          fo;
    logic [W-1:0]  ores;
    logic [3:0]    oflg;

    always #5 clk = ~clk;

    shift_flag_stage #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .sel_i    (sel_i),
        .A_i      (A_i),
        .shamt_i  (shamt_i),
        .data_i   (data_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .flags_o  (flags_o),
        .op_cnt_o (op_cnt_o)
    );

    function automatic logic [3:0] model_flags(logic [1:0] sel, logic [7:0] a,
                                               logic [7:0] s, logic [7:0] d);
        int ai, si, di, msb, n, z, c, v, lim;
        ai  = int'(a);
        si  = int'(s);
        di  = int'(d);
        msb = (ai >> 7) & 1;
        n   = (di >> 7) & 1;
        z   = (di == 0) ? 1 : 0;
        c   = 0;
        if (si >= 1 && si <= 8) begin
            if (sel[1] == 1'b0) c = (ai >> (si - 1)) & 1;
            else                c = (ai >> (8 - si)) & 1;
        end else if (si > 8 && sel == 2'b01) begin
            c = msb;
        end
        v = 0;
        if (sel == 2'b11) begin
            lim = (si > 7) ? 7 : si;
            for (int k = 0; k <= lim; k++) begin
                if (((ai >> (7 - k)) & 1) != msb) v = 1;
            end
        end
        return {n[0], z[0], c[0], v[0]};
    endfunction

    function automatic logic [7:0] sat_cnt(int cnt);
        int lim;
        lim = (1 << CW) - 1;
        return 8'((cnt > lim) ? lim : cnt);
    endfunction

    // One clock: sample handshakes mid-cycle, record accepted inputs, then advance past the edge.
    task automatic tick();
        @(negedge clk);
        fi   = valid_i & ready_o & ~rst_i;
        fo   = valid_o & ready_i & ~rst_i;
        ores = result_o;
        oflg = flags_o;
        if (rst_i) begin
            sb.delete();
            cnt_model = 0;
        end else if (fi) begin
            sb.push_back({data_i, model_flags(sel_i, A_i, shamt_i, data_i)});
            cnt_model++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", ready_o); end
        checks++; if (result_o !== 8'h00) begin errors++; $display("FAIL reset_result got %h required 00", result_o); end
        checks++; if (flags_o !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b required 0000", flags_o); end
        checks++; if (op_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d required 0", op_cnt_o); end
    endtask

    task automatic test_flags();
        logic [1:0] t_sel [9] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b01};
        logic [7:0] t_a   [9] = '{8'h88, 8'h88, 8'h88, 8'h88, 8'h88, 8'h88, 8'h01, 8'h40, 8'h7F};
        logic [7:0] t_s   [9] = '{8'd3,  8'd5,  8'd9,  8'd3,  8'd5,  8'd0,  8'd8,  8'd200, 8'd8};
        logic [7:0] t_d   [9] = '{8'h11, 8'hFC, 8'hFF, 8'h40, 8'h00, 8'h88, 8'h00, 8'h00, 8'h00};
        logic [3:0] t_f   [9] = '{4'b0000, 4'b1000, 4'b1010, 4'b0001, 4'b0110,
                                  4'b1000, 4'b0110, 4'b0101, 4'b0100};
        ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            valid_i = (i < 9);
            if (i < 9) begin
                sel_i = t_sel[i]; A_i = t_a[i]; shamt_i = t_s[i]; data_i = t_d[i];
            end
            tick();
            if (fo) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL flags_sb extra output res=%h flags=%b required none", ores, oflg);
                end else begin
                    exp_e = sb.pop_front();
                    if ({ores, oflg} !== exp_e) begin
                        errors++;
                        $display("FAIL flags_sb got res=%h flags=%b required res=%h flags=%b",
                                 ores, oflg, exp_e[11:4], exp_e[3:0]);
                    end
                end
            end
            if (i < 9) begin
                checks++;
                if (valid_o !== 1'b1 || result_o !== t_d[i] || flags_o !== t_f[i]) begin
                    errors++;
                    $display("FAIL flags_case%0d got vld=%b res=%h flags=%b required vld=1 res=%h flags=%b",
                             i, valid_o, result_o, flags_o, t_d[i], t_f[i]);
                end
            end
        end
        valid_i = 1'b0;
        checks++; if (sb.size() != 0 || valid_o !== 1'b0) begin errors++; $display("FAIL flags_drain got left=%0d vld=%b required 0 0", sb.size(), valid_o); end
    endtask

    task automatic test_stall();
        logic [7:0] s_a [3] = '{8'h81, 8'h42, 8'hC3};
        logic [7:0] s_s [3] = '{8'd1,  8'd2,  8'd4};
        int idx = 0;
        rst_i = 1'b1;
        tick();
        rst_i   = 1'b0;
        ready_i = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            valid_i = (idx < 3);
            if (idx < 3) begin
                sel_i = 2'b10; A_i = s_a[idx]; shamt_i = s_s[idx]; data_i = s_a[idx] << s_s[idx];
            end
            ready_i = (cyc >= 4);
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (ready_o !== 1'b0 || valid_o !== 1'b1 || result_o !== (s_a[0] << s_s[0]) || op_cnt_o !== 4'd2) begin
                    errors++;
                    $display("FAIL stall_full got rdy=%b vld=%b res=%h cnt=%0d required 0 1 %h 2",
                             ready_o, valid_o, result_o, op_cnt_o, s_a[0] << s_s[0]);
                end
            end
            tick();
            if (fi) begin
                idx++;
                if (idx == 3) begin
                    checks++;
                    if (op_cnt_o !== 4'd3) begin errors++; $display("FAIL stall_cnt got %0d required 3", op_cnt_o); end
                end
            end
            if (fo) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL stall_sb extra output res=%h flags=%b required none", ores, oflg);
                end else begin
                    exp_e = sb.pop_front();
                    if ({ores, oflg} !== exp_e) begin
                        errors++;
                        $display("FAIL stall_sb got res=%h flags=%b required res=%h flags=%b",
                                 ores, oflg, exp_e[11:4], exp_e[3:0]);
                    end
                end
            end
        end
        valid_i = 1'b0;
        checks++; if (idx != 3 || sb.size() != 0) begin errors++; $display("FAIL stall_done got sent=%0d left=%0d required 3 0", idx, sb.size()); end
    endtask

    task automatic test_back_to_back();
        logic pending = 1'b0;
        for (int cyc = 0; cyc < 90; cyc++) begin
            if (!pending || fi) begin
                pending = (cyc < 80) && ($urandom_range(0, 3) != 0);
                sel_i   = 2'($urandom_range(0, 3));
                A_i     = 8'($urandom_range(0, 255));
                shamt_i = 8'($urandom_range(0, 12));
                case (sel_i)
                    2'b00:   data_i = A_i >> shamt_i;
                    2'b01:   data_i = $signed(A_i) >>> shamt_i;
                    default: data_i = A_i << shamt_i;
                endcase
            end
            valid_i = pending;
            ready_i = (cyc >= 80) || ($urandom_range(0, 2) != 0);
            tick();
            if (fo) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL b2b_sb extra output res=%h flags=%b required none", ores, oflg);
                end else begin
                    exp_e = sb.pop_front();
                    if ({ores, oflg} !== exp_e) begin
                        errors++;
                        $display("FAIL b2b_sb got res=%h flags=%b required res=%h flags=%b",
                                 ores, oflg, exp_e[11:4], exp_e[3:0]);
                    end
                end
            end
        end
        valid_i = 1'b0;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain got left=%0d required 0", sb.size()); end
        checks++; if (8'(op_cnt_o) !== sat_cnt(cnt_model)) begin errors++; $display("FAIL b2b_cnt_sat got %0d required %0d", op_cnt_o, sat_cnt(cnt_model)); end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b0;
        valid_i = 1'b1;
        sel_i = 2'b00; A_i = 8'hF0; shamt_i = 8'd4; data_i = 8'h0F;
        tick();
        A_i = 8'hAA; shamt_i = 8'd1; data_i = 8'h55;
        tick();
        valid_i = 1'b0;
        checks++; if (ready_o !== 1'b0 || valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_full got rdy=%b vld=%b required 0 1", ready_o, valid_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b required 0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b required 1", ready_o); end
        checks++; if (op_cnt_o !== 4'd0) begin errors++; $display("FAIL rstmid_cnt got %0d required 0", op_cnt_o); end
        checks++; if (result_o !== 8'h00 || flags_o !== 4'b0000) begin errors++; $display("FAIL rstmid_outs got res=%h flags=%b required 00 0000", result_o, flags_o); end
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (fo !== 1'b0) begin errors++; $display("FAIL rstmid_leak got res=%h flags=%b required no output", ores, oflg); end
        end
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        sel_i = 2'b00; A_i = '0; shamt_i = '0; data_i = '0;
        fi = 1'b0; fo = 1'b0; ores = '0; oflg = '0; exp_e = '0;
        test_reset();
        test_flags();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
